// File: rtl/seg_serial_rx.sv
// Seven-segment serial stream receiver: rebuilds the parallel segment frame
// from shift clock, data, refresh enable and clear, all oversampled on clk.
module seg_serial_rx #(
  parameter int FRAME_BITS  = 64,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 1024,
  parameter int CNT_W       = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  segclk_in,
  input  logic                  segsout_in,
  input  logic                  SEGEN_in,
  input  logic                  segclrn_in,
  output logic [FRAME_BITS-1:0] frame_data,
  output logic                  frame_valid,
  output logic                  frame_err,
  output logic [CNT_W-1:0]      bit_count,
  output logic                  busy
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0] OVER_CNT = CNT_W'(FRAME_BITS + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, FULL, OVER} state_t;

  state_t state, state_n, state_s;

  logic [SYNC_STAGES-1:0] clk_s, dat_s, en_s, clrn_s;
  logic clk_h, en_h;
  logic shift_ev, latch_ev, clr, din;

  logic [FRAME_BITS-1:0] shift_reg, sr_n, sr_s, fd_n;
  logic [CNT_W-1:0] cnt_n;
  logic [TW-1:0] tmo, tmo_n;
  logic valid_n, err_n;

  // Idle levels loaded on reset so no spurious edge follows release
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_s  <= '0;
      dat_s  <= '0;
      en_s   <= '0;
      clrn_s <= '1;
      clk_h  <= 1'b0;
      en_h   <= 1'b0;
    end else begin
      clk_s  <= {clk_s[SYNC_STAGES-2:0], segclk_in};
      dat_s  <= {dat_s[SYNC_STAGES-2:0], segsout_in};
      en_s   <= {en_s[SYNC_STAGES-2:0], SEGEN_in};
      clrn_s <= {clrn_s[SYNC_STAGES-2:0], segclrn_in};
      clk_h  <= clk_s[SYNC_STAGES-1];
      en_h   <= en_s[SYNC_STAGES-1];
    end
  end

  assign shift_ev = clk_s[SYNC_STAGES-1] & ~clk_h;
  assign latch_ev = en_s[SYNC_STAGES-1] & ~en_h;
  assign clr      = ~clrn_s[SYNC_STAGES-1];
  assign din      = dat_s[SYNC_STAGES-1];

  always_comb begin
    state_n = state;
    state_s = state;
    sr_s    = shift_reg;
    sr_n    = shift_reg;
    cnt_n   = bit_count;
    tmo_n   = tmo;
    fd_n    = frame_data;
    valid_n = 1'b0;
    err_n   = 1'b0;
    if (shift_ev) begin
      sr_s  = {shift_reg[FRAME_BITS-2:0], din};
      cnt_n = (bit_count == OVER_CNT) ? bit_count : bit_count + 1'b1;
      tmo_n = '0;
      unique case (1'b1)
        cnt_n == FULL_CNT: state_s = FULL;
        cnt_n == OVER_CNT: state_s = OVER;
        default:           state_s = SHIFT;
      endcase
      state_n = state_s;
      sr_n    = sr_s;
    end else if (state != IDLE) begin
      if (tmo == TMO_LAST) begin
        err_n   = 1'b1;
        cnt_n   = '0;
        state_n = IDLE;
        tmo_n   = '0;
      end else begin
        tmo_n = tmo + 1'b1;
      end
    end
    // Latch judges the post-shift state, never the timed-out one
    if (latch_ev) begin
      valid_n = (state_s == FULL);
      err_n   = (state_s != FULL);
      if (state_s == FULL) fd_n = sr_s;
      cnt_n   = '0;
      state_n = IDLE;
      tmo_n   = '0;
    end
    if (clr) begin
      sr_n    = '0;
      cnt_n   = '0;
      state_n = IDLE;
      tmo_n   = '0;
      fd_n    = frame_data;
      valid_n = 1'b0;
      err_n   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      shift_reg   <= '0;
      frame_data  <= '0;
      bit_count   <= '0;
      tmo         <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      state       <= state_n;
      shift_reg   <= sr_n;
      frame_data  <= fd_n;
      bit_count   <= cnt_n;
      tmo         <= tmo_n;
      frame_valid <= valid_n;
      frame_err   <= err_n;
    end
  end

  assign busy = (bit_count != '0);

endmodule

// File: tb/tb_seg_serial_rx.sv
// Directed bench for seg_serial_rx: expected frame pulses are queued by the
// stimulus and matched by an independent monitor.
module tb_seg_serial_rx;

  localparam int FB = 64;
  localparam int TMO = 1024;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic segclk_in = 1'b0;
  logic segsout_in = 1'b0;
  logic SEGEN_in = 1'b0;
  logic segclrn_in = 1'b1;
  logic [FB-1:0] frame_data;
  logic frame_valid, frame_err;
  logic [6:0] bit_count;
  logic busy;

  typedef struct {
    bit        is_valid;
    logic [63:0] data;
  } exp_t;

  exp_t q[$];
  int n_chk = 0;
  int n_fail = 0;
  logic [63:0] last_good = '0;

  seg_serial_rx #(
    .FRAME_BITS(FB), .SYNC_STAGES(2), .TIMEOUT(TMO), .CNT_W(7)
  ) dut (
    .clk(clk), .rst(rst),
    .segclk_in(segclk_in), .segsout_in(segsout_in),
    .SEGEN_in(SEGEN_in), .segclrn_in(segclrn_in),
    .frame_data(frame_data), .frame_valid(frame_valid),
    .frame_err(frame_err), .bit_count(bit_count), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input bit v, input logic [63:0] d);
    exp_t e;
    e.is_valid = v;
    e.data = d;
    q.push_back(e);
    if (v) last_good = d;
  endtask

  task automatic send_bit(input logic b);
    segsout_in = b;
    segclk_in = 1'b0;
    repeat (4) @(negedge clk);
    segclk_in = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic send_word(input logic [63:0] v, input int n);
    for (int i = 0; i < n; i++) send_bit(v[63 - (i % 64)]);
  endtask

  task automatic pulse_en();
    SEGEN_in = 1'b1;
    repeat (4) @(negedge clk);
    SEGEN_in = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (!rst && (frame_valid || frame_err)) begin
      exp_t e;
      n_chk++;
      if (frame_valid && frame_err) begin
        n_fail++;
        $display("FAIL both_pulses: valid=%b err=%b required one", frame_valid,
                 frame_err);
      end else if (q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_pulse: valid=%b err=%b data=%h", frame_valid,
                 frame_err, frame_data);
      end else begin
        e = q.pop_front();
        if (e.is_valid != frame_valid || frame_data !== e.data) begin
          n_fail++;
          $display("FAIL pulse: valid=%b data=%h expected valid=%b data=%h",
                   frame_valid, frame_data, e.is_valid, e.data);
        end
      end
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_data", frame_data, 64'h0);
    chk("rst_valid", {63'h0, frame_valid}, 64'h0);
    chk("rst_err", {63'h0, frame_err}, 64'h0);
    chk("rst_count", {57'h0, bit_count}, 64'h0);
    chk("rst_busy", {63'h0, busy}, 64'h0);

    send_word(64'hF0E1_D2C3_B4A5_9687, 64);
    chk("full_count", {57'h0, bit_count}, 64'd64);
    chk("full_busy", {63'h0, busy}, 64'h1);
    push(1'b1, 64'hF0E1_D2C3_B4A5_9687);
    pulse_en();
    chk("after_latch_count", {57'h0, bit_count}, 64'h0);
    chk("good_frame_data", frame_data, 64'hF0E1_D2C3_B4A5_9687);

    send_word(64'hAAAA_5555_AAAA_5555, 63);
    chk("short_count", {57'h0, bit_count}, 64'd63);
    push(1'b0, last_good);
    pulse_en();
    send_word(64'h1357_9BDF_2468_ACE0, 65);
    chk("sat_count", {57'h0, bit_count}, 64'd65);
    push(1'b0, last_good);
    pulse_en();
    chk("held_data", frame_data, 64'hF0E1_D2C3_B4A5_9687);

    send_word(64'hFFFF_FFFF_FFFF_FFFF, 40);
    segclrn_in = 1'b0;
    repeat (4) @(negedge clk);
    segclrn_in = 1'b1;
    repeat (4) @(negedge clk);
    chk("clear_count", {57'h0, bit_count}, 64'h0);
    send_word(64'h0123_4567_89AB_CDEF, 64);
    push(1'b1, 64'h0123_4567_89AB_CDEF);
    pulse_en();

    send_word(64'h8000_0000_0000_0001, 20);
    chk("partial_busy", {63'h0, busy}, 64'h1);
    push(1'b0, last_good);
    repeat (TMO + 10) @(negedge clk);
    chk("tmo_count", {57'h0, bit_count}, 64'h0);
    chk("tmo_busy", {63'h0, busy}, 64'h0);
    chk("tmo_drained", 64'(q.size()), 64'h0);
    send_word(64'hA5A5_5A5A_0FF0_C33C, 64);
    push(1'b1, 64'hA5A5_5A5A_0FF0_C33C);
    pulse_en();

    begin
      logic [63:0] v;
      v = 64'h1122_3344_5566_7788;
      send_word(v, 63);
      segsout_in = v[0];
      segclk_in = 1'b0;
      repeat (4) @(negedge clk);
      push(1'b1, v);
      segclk_in = 1'b1;
      SEGEN_in = 1'b1;
      repeat (4) @(negedge clk);
      SEGEN_in = 1'b0;
      repeat (6) @(negedge clk);
      chk("coinc_count", {57'h0, bit_count}, 64'h0);
    end

    send_word(64'hDEAD_BEEF_CAFE_F00D, 64);
    segclrn_in = 1'b0;
    SEGEN_in = 1'b1;
    repeat (4) @(negedge clk);
    segclrn_in = 1'b1;
    SEGEN_in = 1'b0;
    repeat (6) @(negedge clk);
    chk("clr_latch_count", {57'h0, bit_count}, 64'h0);
    chk("clr_latch_data", frame_data, 64'h1122_3344_5566_7788);

    send_word(64'h0F0F_F0F0_3C3C_C3C3, 30);
    chk("mid_count", {57'h0, bit_count}, 64'd30);
    #2 rst = 1'b1;
    #1;
    chk("arst_data", frame_data, 64'h0);
    chk("arst_count", {57'h0, bit_count}, 64'h0);
    chk("arst_busy", {63'h0, busy}, 64'h0);
    chk("arst_pulses", {62'h0, frame_valid, frame_err}, 64'h0);
    @(negedge clk);
    rst = 1'b0;
    segclk_in = 1'b0;
    repeat (20) @(negedge clk);
    chk("post_rst_data", frame_data, 64'h0);

    chk("queue_empty", 64'(q.size()), 64'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk,
             n_fail);
    $finish;
  end

endmodule

// File: doc/seg_serial_rx.md
Name: seg_serial_rx

Overview:
- Receive-side partner of the seven-segment serial display driver; reconstructs the parallel segment frame from the four-wire serial stream: shift clock, serial data, refresh enable, clear.
- Used in the IO subsystem as a loop-back checker and as the input stage of a mirror display.
- Oversamples all serial lines in the system clock domain, shifts MSB-first, and latches a complete frame on the refresh-enable rising edge.

Parameters:
- FRAME_BITS, 64, bits per frame: 8 digits x 8 segments.
- SYNC_STAGES, 2, synchronizer flops per serial input (minimum 2).
- TIMEOUT, 1024, clk cycles without a shift-clock rising edge before a partial frame is abandoned.
- CNT_W, 7, width of the bit counter; must hold FRAME_BITS+1.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- segclk_in  input  1  serial shift clock from the transmitter.
- segsout_in  input  1  serial segment data; valid at the segclk_in rising edge.
- SEGEN_in  input  1  refresh enable; its rising edge requests a frame latch.
- segclrn_in  input  1  active-low clear of the receive shift chain.
- frame_data  output  FRAME_BITS  last good frame; the first bit received lands in bit FRAME_BITS-1.
- frame_valid  output  1  one-cycle pulse when frame_data is updated.
- frame_err  output  1  one-cycle pulse on a short frame, an overlong frame, or a timeout.
- bit_count  output  CNT_W  bits shifted since the last clear or latch; saturates at FRAME_BITS+1.
- busy  output  1  high while 0 < bit_count.

Behaviour:
- Reset (rst=1, asynchronous): all synchronizer flops load their idle values (segclk 0, segsout 0, SEGEN 0, segclrn 1). shift_reg=0, frame_data=0, bit_count=0, frame_valid=0, frame_err=0, busy=0, timeout counter=0, state=IDLE.
- Sync: each input passes through SYNC_STAGES flops, followed by one history flop for edge detection. Edge events lag the pins by SYNC_STAGES+1 cycles.
- Shift event (synchronized segclk rising edge):
  - shift_reg <= {shift_reg[FRAME_BITS-2:0], segsout_sync}.
  - bit_count increments, saturating at FRAME_BITS+1.
  - Timeout counter clears.
- States:
  - IDLE (bit_count=0): a shift event goes to SHIFT.
  - SHIFT (0<count<FRAME_BITS): count reaching FRAME_BITS goes to FULL.
  - FULL (count=FRAME_BITS): a further shift event goes to OVER.
  - OVER (count=FRAME_BITS+1): further shifts are ignored for counting; data still shifts.
- Latch event (synchronized SEGEN rising edge):
  - In FULL: frame_data <= shift_reg, frame_valid=1 for one cycle.
  - In IDLE, SHIFT or OVER: frame_err=1 for one cycle and frame_data is held.
  - In every case bit_count <= 0 and state goes to IDLE; shift_reg is kept.
- Clear (synchronized segclrn = 0, level):
  - Holds shift_reg=0, bit_count=0, state=IDLE. Does not touch frame_data.
  - Generates no error pulse.
- Timeout:
  - Active only in SHIFT, FULL and OVER; counts clk cycles.
  - At TIMEOUT-1 with no shift event: frame_err pulse, bit_count=0, IDLE, timeout counter=0.
- Priority within a single cycle: clear > latch > shift > timeout.
  - A shift and a latch in the same cycle: the latch evaluates the post-shift count and data, so the 64th bit arriving with SEGEN still produces a valid frame.
  - A clear in the same cycle as a latch: clear wins, with no valid or err pulse.
- frame_valid and frame_err are never high in the same cycle.
- Outputs are registered; busy is derived from the registered bit_count.
- Reset asserted mid-frame aborts the frame with no pulse.

Test Plan:
- Send 64 bits of 0xF0E1_D2C3_B4A5_9687 MSB-first at segclk = clk/8, then pulse SEGEN -> frame_valid pulses once, frame_data=0xF0E1D2C3B4A59687, bit_count returns to 0, frame_err stays 0.
- Send 63 bits, then SEGEN -> frame_err pulse; frame_data keeps the previous value; then 65 bits and SEGEN -> frame_err, bit_count had saturated at 65.
- Send 40 bits, drive segclrn low for 4 clk, then a full 64-bit frame of 0x0123_4567_89AB_CDEF -> frame_valid with exactly that value, no frame_err.
- Send 20 bits, then idle for TIMEOUT+10 cycles -> exactly one frame_err, bit_count=0, busy=0; a following good frame latches correctly.
- The 64th segclk rising edge and the SEGEN rising edge on the same clk edge -> frame_valid with the correct data. Separately, segclrn low coincident with SEGEN rising -> neither pulse.
- Assert rst for 1 cycle asynchronously (between clk edges) mid-frame -> all outputs 0 immediately, with no pulse after release.
